sd_regbank_bridge: RTL and testbench



---
 rtl/sd_regbank_pkg.sv | 84 ++++++++
 rtl/sd_stage_reg.sv | 35 +++
 rtl/sd_regbank_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_sd_regbank_bridge.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_regbank_pkg.sv
// Shared register map, field widths and helpers for the SD controller register bank.
package sd_regbank_pkg;

   localparam logic [6:0] OFF_ARGUMENT     = 7'h00;
   localparam logic [6:0] OFF_COMMAND      = 7'h04;
   localparam logic [6:0] OFF_RESP0        = 7'h08;
   localparam logic [6:0] OFF_RESP1        = 7'h0C;
   localparam logic [6:0] OFF_RESP2        = 7'h10;
   localparam logic [6:0] OFF_RESP3        = 7'h14;
   localparam logic [6:0] OFF_DATA_TIMEOUT = 7'h18;
   localparam logic [6:0] OFF_CONTROLLER   = 7'h1C;
   localparam logic [6:0] OFF_CMD_TIMEOUT  = 7'h20;
   localparam logic [6:0] OFF_CLOCK_DIV    = 7'h24;
   localparam logic [6:0] OFF_RESET        = 7'h28;
   localparam logic [6:0] OFF_VOLTAGE      = 7'h2C;
   localparam logic [6:0] OFF_CAPA         = 7'h30;
   localparam logic [6:0] OFF_CMD_ISR      = 7'h34;
   localparam logic [6:0] OFF_DATA_ISR     = 7'h3C;
   localparam logic [6:0] OFF_BLKSIZE      = 7'h44;
   localparam logic [6:0] OFF_BLKCNT       = 7'h48;

   localparam int CMD_REG_W      = 14;
   localparam int CMD_TIMEOUT_W  = 24;
   localparam int DATA_TIMEOUT_W = 24;
   localparam int BLKSIZE_W      = 12;
   localparam int BLKCNT_W       = 16;
   localparam int INT_CMD_W      = 5;
   localparam int INT_DATA_W     = 3;
   localparam int CTRL_W         = 16;
   localparam int CLKDIV_W       = 8;
   localparam int SWRST_W        = 1;

   localparam logic [BLKSIZE_W-1:0] RESET_BLOCK_SIZE = 12'd512;

   localparam int NUM_WR = 9;
   typedef enum logic [3:0] {
      WR_ARGUMENT, WR_COMMAND, WR_DATA_TIMEOUT, WR_CONTROLLER, WR_CMD_TIMEOUT,
      WR_CLOCK_DIV, WR_RESET, WR_BLKSIZE, WR_BLKCNT
   } wr_reg_e;

   // Byte lanes touched by a beat of nbytes starting at lane lo.
   function automatic logic [3:0] lane_mask(input logic [1:0] lo, input int nbytes);
      logic [3:0] m;
      for (int i = 0; i < 4; i++) m[i] = (i >= int'(lo)) && (i < int'(lo) + nbytes);
      return m;
   endfunction

   function automatic logic [6:0] wr_offset(input int i);
      case (wr_reg_e'(i))
         WR_ARGUMENT:     return OFF_ARGUMENT;
         WR_COMMAND:      return OFF_COMMAND;
         WR_DATA_TIMEOUT: return OFF_DATA_TIMEOUT;
         WR_CONTROLLER:   return OFF_CONTROLLER;
         WR_CMD_TIMEOUT:  return OFF_CMD_TIMEOUT;
         WR_CLOCK_DIV:    return OFF_CLOCK_DIV;
         WR_RESET:        return OFF_RESET;
         WR_BLKSIZE:      return OFF_BLKSIZE;
         default:         return OFF_BLKCNT;
      endcase
   endfunction

   function automatic int wr_width(input int i);
      case (wr_reg_e'(i))
         WR_ARGUMENT:     return 32;
         WR_COMMAND:      return CMD_REG_W;
         WR_DATA_TIMEOUT: return DATA_TIMEOUT_W;
         WR_CONTROLLER:   return CTRL_W;
         WR_CMD_TIMEOUT:  return CMD_TIMEOUT_W;
         WR_CLOCK_DIV:    return CLKDIV_W;
         WR_RESET:        return SWRST_W;
         WR_BLKSIZE:      return BLKSIZE_W;
         default:         return BLKCNT_W;
      endcase
   endfunction

   function automatic logic [31:0] wr_reset(input int i);
      case (wr_reg_e'(i))
         WR_CLOCK_DIV: return 32'd1;
         WR_BLKSIZE:   return 32'(RESET_BLOCK_SIZE);
         default:      return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/sd_stage_reg.sv
// One byte-maskable configuration register, loaded from the staged word when a write commits.
module sd_stage_reg
   import sd_regbank_pkg::*;
#(
   parameter int          W         = 32,
   parameter logic [31:0] RESET_VAL = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit,
   input  logic [3:0]  mask,
   input  logic [31:0] data,
   output logic [31:0] value
);

   logic [W-1:0] value_q, value_d;
   logic         unused_data;

   // Bytes beyond W simply fall away, which is how narrow registers truncate.
   always_comb begin
      value_d = value_q;
      for (int i = 0; i < W; i++) begin
         if (commit && mask[i/8]) value_d[i] = data[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) value_q <= RESET_VAL[W-1:0];
      else     value_q <= value_d;
   end

   assign value       = 32'(value_q);
   assign unused_data = ^data;

endmodule

// File: rtl/sd_regbank_bridge.sv
// Byte/half-word/word bus front end for the SD controller register bank with atomic staged writes.
// Define SD_REG_SNAPSHOT_EN to serve multi-beat reads from a snapshot taken on the lane-0 beat.
module sd_regbank_bridge
   import sd_regbank_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter int          SUPPLY_MV = 3300,
   parameter logic [15:0] CAPA      = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req,
   input  logic                      we,
   input  logic [6:0]                addr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [DATA_W/8-1:0]       be,
   output logic                      ack,
   output logic [DATA_W-1:0]         rdata,
   output logic                      cmd_start,
   output logic                      cmd_int_rst,
   output logic                      data_int_rst,
   output logic [31:0]               argument,
   output logic [CMD_REG_W-1:0]      command,
   output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout,
   output logic [DATA_TIMEOUT_W-1:0] data_timeout,
   output logic [BLKSIZE_W-1:0]      block_size,
   output logic [BLKCNT_W-1:0]       block_count,
   output logic [CLKDIV_W-1:0]       clock_div,
   output logic [CTRL_W-1:0]         controller,
   output logic [SWRST_W-1:0]        sw_reset,
   input  logic [31:0]               resp0,
   input  logic [31:0]               resp1,
   input  logic [31:0]               resp2,
   input  logic [31:0]               resp3,
   input  logic [INT_CMD_W-1:0]      cmd_isr,
   input  logic [INT_DATA_W-1:0]     data_isr
);

   localparam int NB = DATA_W / 8;

   logic [1:0]  lane_lo;
   logic [3:0]  lanes, be_lanes, pmask_eff, upd_mask;
   logic [4:0]  reg_idx;
   logic [31:0] wdata32, merged, live_val, rd_val, rd_shift;
   logic        commit, wr_beat, rd_beat, unused_rd;

   logic              ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              cmd_start_q, cmd_start_d;
   logic              cmd_int_rst_q, cmd_int_rst_d;
   logic              data_int_rst_q, data_int_rst_d;
   logic [31:0]       shadow_q, shadow_d;
   logic [3:0]        pmask_q, pmask_d;
   logic [4:0]        ptag_q, ptag_d;

   assign lane_lo  = addr[1:0] & ~2'(NB - 1);
   assign lanes    = lane_mask(lane_lo, NB);
   assign be_lanes = 4'(be) << lane_lo;
   assign wdata32  = 32'(wdata) << {lane_lo, 3'b000};
   assign reg_idx  = addr[6:2];
   assign commit   = lanes[3];
   assign wr_beat  = req & we;
   assign rd_beat  = req & ~we;

   // Pending bytes only count toward the register they were staged for.
   assign pmask_eff = (ptag_q == reg_idx) ? pmask_q : 4'b0000;
   assign upd_mask  = pmask_eff | be_lanes;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be_lanes[gi] ? wdata32[gi*8 +: 8] : shadow_q[gi*8 +: 8];
   end

   logic [31:0]       reg_val [NUM_WR];
   logic [NUM_WR-1:0] reg_commit;

   for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_reg
      localparam logic [6:0] OFF = wr_offset(gi);
      assign reg_commit[gi] = wr_beat && commit && (reg_idx == OFF[6:2]);
      sd_stage_reg #(
         .W         (wr_width(gi)),
         .RESET_VAL (wr_reset(gi))
      ) u_reg (
         .clk    (clk),
         .rst    (rst),
         .commit (reg_commit[gi]),
         .mask   (upd_mask),
         .data   (merged),
         .value  (reg_val[gi])
      );
   end

   assign argument     = reg_val[WR_ARGUMENT];
   assign command      = reg_val[WR_COMMAND][CMD_REG_W-1:0];
   assign data_timeout = reg_val[WR_DATA_TIMEOUT][DATA_TIMEOUT_W-1:0];
   assign controller   = reg_val[WR_CONTROLLER][CTRL_W-1:0];
   assign cmd_timeout  = reg_val[WR_CMD_TIMEOUT][CMD_TIMEOUT_W-1:0];
   assign clock_div    = reg_val[WR_CLOCK_DIV][CLKDIV_W-1:0];
   assign sw_reset     = reg_val[WR_RESET][SWRST_W-1:0];
   assign block_size   = reg_val[WR_BLKSIZE][BLKSIZE_W-1:0];
   assign block_count  = reg_val[WR_BLKCNT][BLKCNT_W-1:0];

   always_comb begin
      live_val = '0;
      case (reg_idx)
         OFF_RESP0[6:2]:    live_val = resp0;
         OFF_RESP1[6:2]:    live_val = resp1;
         OFF_RESP2[6:2]:    live_val = resp2;
         OFF_RESP3[6:2]:    live_val = resp3;
         OFF_VOLTAGE[6:2]:  live_val = 32'(SUPPLY_MV);
         OFF_CAPA[6:2]:     live_val = 32'(CAPA);
         OFF_CMD_ISR[6:2]:  live_val = 32'(cmd_isr);
         OFF_DATA_ISR[6:2]: live_val = 32'(data_isr);
         default:           live_val = '0;
      endcase
      for (int i = 0; i < NUM_WR; i++) begin
         if (reg_idx == 5'(wr_offset(i) >> 2)) live_val = reg_val[i];
      end
   end

`ifdef SD_REG_SNAPSHOT_EN
   logic [31:0] snap_q, snap_d;
   logic        snap_valid_q, snap_valid_d;
   logic [4:0]  snap_tag_q, snap_tag_d;

   always_comb begin
      snap_d       = snap_q;
      snap_valid_d = snap_valid_q;
      snap_tag_d   = snap_tag_q;
      if (rd_beat && lanes[0]) begin
         snap_d       = live_val;
         snap_valid_d = 1'b1;
         snap_tag_d   = reg_idx;
      end
   end

   assign rd_val = (!lanes[0] && snap_valid_q && (snap_tag_q == reg_idx)) ? snap_q : live_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         snap_tag_q   <= '0;
      end else begin
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         snap_tag_q   <= snap_tag_d;
      end
   end
`else
   assign rd_val = live_val;
`endif

   assign rd_shift  = rd_val >> {lane_lo, 3'b000};
   assign unused_rd = ^rd_shift;

   always_comb begin
      ack_d          = req;
      rdata_d        = rdata_q;
      cmd_start_d    = 1'b0;
      cmd_int_rst_d  = 1'b0;
      data_int_rst_d = 1'b0;
      shadow_d       = shadow_q;
      pmask_d        = pmask_q;
      ptag_d         = ptag_q;
      if (wr_beat) begin
         ptag_d = reg_idx;
         if (commit) begin
            pmask_d = 4'b0000;
         end else begin
            shadow_d = merged;
            pmask_d  = upd_mask;
         end
         cmd_start_d    = commit && (reg_idx == OFF_ARGUMENT[6:2]);
         cmd_int_rst_d  = lanes[0] && (reg_idx == OFF_CMD_ISR[6:2]);
         data_int_rst_d = lanes[0] && (reg_idx == OFF_DATA_ISR[6:2]);
      end else if (rd_beat) begin
         rdata_d = rd_shift[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q          <= 1'b0;
         rdata_q        <= '0;
         cmd_start_q    <= 1'b0;
         cmd_int_rst_q  <= 1'b0;
         data_int_rst_q <= 1'b0;
         shadow_q       <= '0;
         pmask_q        <= '0;
         ptag_q         <= '0;
      end else begin
         ack_q          <= ack_d;
         rdata_q        <= rdata_d;
         cmd_start_q    <= cmd_start_d;
         cmd_int_rst_q  <= cmd_int_rst_d;
         data_int_rst_q <= data_int_rst_d;
         shadow_q       <= shadow_d;
         pmask_q        <= pmask_d;
         ptag_q         <= ptag_d;
      end
   end

   assign ack          = ack_q;
   assign rdata        = rdata_q;
   assign cmd_start    = cmd_start_q;
   assign cmd_int_rst  = cmd_int_rst_q;
   assign data_int_rst = data_int_rst_q;

endmodule

// File: tb/tb_sd_regbank_bridge.sv
// Directed bench driving 8-, 16- and 32-bit instances of sd_regbank_bridge side by side.
module tb_sd_regbank_bridge;
   import sd_regbank_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic        we;
   logic [6:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [2:0]  ack, cmd_start, cmd_int_rst, data_int_rst;
   logic [7:0]  rdata8;
   logic [15:0] rdata16;
   logic [31:0] rdata32;
   logic [31:0]               argument     [3];
   logic [CMD_REG_W-1:0]      command      [3];
   logic [CMD_TIMEOUT_W-1:0]  cmd_timeout  [3];
   logic [DATA_TIMEOUT_W-1:0] data_timeout [3];
   logic [BLKSIZE_W-1:0]      block_size   [3];
   logic [BLKCNT_W-1:0]       block_count  [3];
   logic [CLKDIV_W-1:0]       clock_div    [3];
   logic [CTRL_W-1:0]         controller   [3];
   logic [SWRST_W-1:0]        sw_reset     [3];
   logic [31:0]               resp0, resp1, resp2, resp3;
   logic [INT_CMD_W-1:0]      cmd_isr;
   logic [INT_DATA_W-1:0]     data_isr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sd_regbank_bridge #(.DATA_W(8)) u8 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we), .addr(addr), .wdata(wdata[7:0]), .be(be[0:0]),
      .ack(ack[0]), .rdata(rdata8), .cmd_start(cmd_start[0]), .cmd_int_rst(cmd_int_rst[0]),
      .data_int_rst(data_int_rst[0]), .argument(argument[0]), .command(command[0]),
      .cmd_timeout(cmd_timeout[0]), .data_timeout(data_timeout[0]), .block_size(block_size[0]),
      .block_count(block_count[0]), .clock_div(clock_div[0]), .controller(controller[0]),
      .sw_reset(sw_reset[0]), .resp0(resp0), .resp1(resp1), .resp2(resp2), .resp3(resp3),
      .cmd_isr(cmd_isr), .data_isr(data_isr));

   sd_regbank_bridge #(.DATA_W(16)) u16 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we), .addr(addr), .wdata(wdata[15:0]), .be(be[1:0]),
      .ack(ack[1]), .rdata(rdata16), .cmd_start(cmd_start[1]), .cmd_int_rst(cmd_int_rst[1]),
      .data_int_rst(data_int_rst[1]), .argument(argument[1]), .command(command[1]),
      .cmd_timeout(cmd_timeout[1]), .data_timeout(data_timeout[1]), .block_size(block_size[1]),
      .block_count(block_count[1]), .clock_div(clock_div[1]), .controller(controller[1]),
      .sw_reset(sw_reset[1]), .resp0(resp0), .resp1(resp1), .resp2(resp2), .resp3(resp3),
      .cmd_isr(cmd_isr), .data_isr(data_isr));

   sd_regbank_bridge #(.DATA_W(32)) u32 (
      .clk(clk), .rst(rst), .req(req[2]), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .ack(ack[2]), .rdata(rdata32), .cmd_start(cmd_start[2]), .cmd_int_rst(cmd_int_rst[2]),
      .data_int_rst(data_int_rst[2]), .argument(argument[2]), .command(command[2]),
      .cmd_timeout(cmd_timeout[2]), .data_timeout(data_timeout[2]), .block_size(block_size[2]),
      .block_count(block_count[2]), .clock_div(clock_div[2]), .controller(controller[2]),
      .sw_reset(sw_reset[2]), .resp0(resp0), .resp1(resp1), .resp2(resp2), .resp3(resp3),
      .cmd_isr(cmd_isr), .data_isr(data_isr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One beat on instance k; returns 1 time unit after the edge that sampled it (ack visible).
   task automatic beat(input int k, input logic w, input logic [6:0] a, input logic [31:0] d,
                       input logic [3:0] b);
      @(negedge clk);
      we = w; addr = a; wdata = d; be = b;
      req = '0; req[k] = 1'b1;
      @(posedge clk); #1;
      req = '0;
      $display("beat dut%0d we=%0b addr=%h wdata=%h be=%b", k, w, a, d, b);
   endtask

   logic [6:0]  b2b_addr [4] = '{7'h2C, 7'h2E, 7'h44, 7'h24};
   logic [15:0] b2b_exp  [4] = '{16'h0CE4, 16'h0000, 16'h0200, 16'h0001};
   logic [15:0] snap_exp;

   initial begin
      rst = 1'b1; req = '0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      resp0 = '0; resp1 = '0; resp2 = '0; resp3 = '0; cmd_isr = '0; data_isr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_clock_div", 32'(clock_div[0]), 32'h1);
      chk("rst_block_size", 32'(block_size[1]), 32'd512);
      chk("rst_argument", argument[2], 32'h0);
      chk("rst_rdata", 32'(rdata16), 32'h0);
      chk("rst_cmd_start", 32'(cmd_start), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Byte-wise staging of argument on the 8-bit bus
      beat(0, 1'b1, 7'h00, 32'h11, 4'h1);
      chk("s1_ack", 32'(ack[0]), 32'h1);
      chk("s1_arg_b0", argument[0], 32'h0);
      beat(0, 1'b1, 7'h01, 32'h22, 4'h1);
      chk("s1_arg_b1", argument[0], 32'h0);
      beat(0, 1'b1, 7'h02, 32'h33, 4'h1);
      chk("s1_arg_b2", argument[0], 32'h0);
      beat(0, 1'b1, 7'h03, 32'h44, 4'h1);
      chk("s1_arg_commit", argument[0], 32'h44332211);
      chk("s1_cmd_start", 32'(cmd_start[0]), 32'h1);
      @(posedge clk); #1;
      chk("s1_cmd_start_once", 32'(cmd_start[0]), 32'h0);
      chk("s1_ack_drop", 32'(ack[0]), 32'h0);

      // A write to another register discards pending bytes
      beat(0, 1'b1, 7'h44, 32'hAA, 4'h1);
      beat(0, 1'b1, 7'h00, 32'h55, 4'h1);
      beat(0, 1'b1, 7'h47, 32'h77, 4'h1);
      chk("s2_blksize_kept", 32'(block_size[0]), 32'd512);
      chk("s2_arg_kept", argument[0], 32'h44332211);
      beat(0, 1'b1, 7'h03, 32'h99, 4'h1);
      chk("s2_arg_byte3", argument[0], 32'h99332211);
      beat(0, 1'b1, 7'h44, 32'h21, 4'h1);
      beat(0, 1'b1, 7'h45, 32'h34, 4'h1);
      beat(0, 1'b1, 7'h47, 32'h00, 4'h1);
      chk("s2_blksize_trunc", 32'(block_size[0]), 32'h421);

      // Byte reads on the 8-bit bus
      beat(0, 1'b0, 7'h2C, 32'h0, 4'h0);
      chk("s3_volt_lo", 32'(rdata8), 32'hE4);
      beat(0, 1'b0, 7'h2D, 32'h0, 4'h0);
      chk("s3_volt_hi", 32'(rdata8), 32'h0C);
      beat(0, 1'b0, 7'h70, 32'h0, 4'h0);
      chk("s3_unmapped", 32'(rdata8), 32'h00);
      beat(0, 1'b0, 7'h00, 32'h0, 4'h0);
      chk("s3_arg_b0", 32'(rdata8), 32'h11);
      beat(0, 1'b0, 7'h45, 32'h0, 4'h0);
      chk("s3_blk_b1", 32'(rdata8), 32'h04);

      // Half-word reads of a live status register
      resp0 = 32'h12345678;
      beat(1, 1'b0, 7'h08, 32'h0, 4'h0);
      chk("s4_resp0_lo", 32'(rdata16), 32'h5678);
      resp0 = 32'h0;
`ifdef SD_REG_SNAPSHOT_EN
      snap_exp = 16'h1234;
`else
      snap_exp = 16'h0000;
`endif
      beat(1, 1'b0, 7'h0A, 32'h0, 4'h0);
      chk("s4_resp0_hi", 32'(rdata16), 32'(snap_exp));

      // Interrupt-reset pulses and word writes
      beat(2, 1'b1, 7'h34, 32'h0, 4'b0001);
      chk("s5_int_rst_be1", 32'(cmd_int_rst[2]), 32'h1);
      @(posedge clk); #1;
      chk("s5_int_rst_clear", 32'(cmd_int_rst[2]), 32'h0);
      beat(2, 1'b1, 7'h34, 32'h0, 4'b0000);
      chk("s5_int_rst_be0", 32'(cmd_int_rst[2]), 32'h1);
      beat(0, 1'b1, 7'h35, 32'h0, 4'h1);
      chk("s5_int_rst_lane1", 32'(cmd_int_rst[0]), 32'h0);
      beat(0, 1'b1, 7'h3C, 32'h0, 4'h0);
      chk("s5_data_int_rst", 32'(data_int_rst[0]), 32'h1);
      beat(2, 1'b1, 7'h00, 32'hDEADBEEF, 4'hF);
      chk("s5_arg_word", argument[2], 32'hDEADBEEF);
      chk("s5_cmd_start", 32'(cmd_start[2]), 32'h1);
      beat(2, 1'b1, 7'h00, 32'h12345678, 4'b0011);
      chk("s5_arg_partial", argument[2], 32'hDEAD5678);

      // Reset in the middle of a staged sequence
      beat(0, 1'b1, 7'h00, 32'hA1, 4'h1);
      beat(0, 1'b1, 7'h01, 32'hB2, 4'h1);
      chk("s6_ack_before_rst", 32'(ack[0]), 32'h1);
      rst = 1'b1;
      #1;
      chk("s6_ack_dropped", 32'(ack[0]), 32'h0);
      chk("s6_arg_reset", argument[0], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      beat(0, 1'b1, 7'h03, 32'hC3, 4'h1);
      chk("s6_arg_byte3_only", argument[0], 32'hC3000000);

      // Four back-to-back reads on the 16-bit bus
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         we = 1'b0; addr = b2b_addr[i]; req = 3'b010;
         @(posedge clk); #1;
         $display("b2b read dut1 addr=%h rdata=%h", b2b_addr[i], rdata16);
         chk("s7_b2b_ack", 32'(ack[1]), 32'h1);
         chk("s7_b2b_rdata", 32'(rdata16), 32'(b2b_exp[i]));
      end
      req = '0;
      @(posedge clk); #1;
      chk("s7_ack_end", 32'(ack[1]), 32'h0);
      chk("s7_rdata_hold", 32'(rdata16), 32'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
